// File: rtl/genetic_pkg.sv
// Shared geometry and framing constants for the genetic evaluator and its
// chromosome loader.
package genetic_pkg;
  localparam int ROW       = 1;
  localparam int COL       = 2;
  localparam int OUT       = 1;
  localparam int IN        = 2;
  localparam int BITS_ELEM = 2;
  localparam int BITS_MAT  = ROW * COL * 16;
  localparam int CHROM_W   = BITS_MAT + BITS_ELEM * OUT;
  localparam int NBYTES    = (CHROM_W + 7) / 8;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_e;
endpackage

// File: rtl/chrom_serial_loader_gap_timer.sv
// Saturating idle-gap counter; hit_o flags the cycle the gap reaches TIMEOUT.
module gap_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (en_i && cnt_q != MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires on the idle cycle whose count would land on TIMEOUT.
  assign hit_o = en_i && !clr_i && (cnt_q >= LIM);
endmodule

// File: rtl/chrom_serial_loader.sv
// Byte-stream chromosome loader: SYNC, LSB-first payload, XOR checksum,
// committed to the evaluator bus only on a valid frame.
module chrom_serial_loader #(
  parameter int ROW        = genetic_pkg::ROW,
  parameter int COL        = genetic_pkg::COL,
  parameter int OUT        = genetic_pkg::OUT,
  parameter int BITS_ELEM  = genetic_pkg::BITS_ELEM,
  parameter int CHROM_W    = ROW * COL * 16 + BITS_ELEM * OUT,
  parameter int NBYTES     = (CHROM_W + 7) / 8,
  parameter int TIMEOUT    = 50000,
  parameter logic [CHROM_W-1:0] INIT_CHROM = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [CHROM_W-1:0] cromossomo,
  output logic               busy,
  output logic               load_done,
  output logic               load_err
);
  import genetic_pkg::*;

  localparam int IDX_W = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [CHROM_W-1:0] shadow_q, shadow_d;
  logic [CHROM_W-1:0] chrom_q, chrom_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               tmo;
  logic               tmr_clr;

  assign tmr_clr = (state_q == IDLE) || rx_valid;

  gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .clr_i (tmr_clr),
    .en_i  (!tmr_clr),
    .hit_o (tmo)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    shadow_d = shadow_q;
    chrom_d  = chrom_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d  = PAYLOAD;
          idx_d    = '0;
          csum_d   = '0;
          shadow_d = '0;
        end
      end
      PAYLOAD: begin
        if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (rx_valid) begin
          // Bits past CHROM_W in the last byte are dropped; csum still sees them.
          for (int b = 0; b < CHROM_W; b++)
            if (int'(idx_q) == b / 8) shadow_d[b] = rx_data[b % 8];
          csum_d = csum_q ^ rx_data;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = CHECK;
        end
      end
      CHECK: begin
        if (tmo) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (rx_valid) begin
          state_d = IDLE;
          if (rx_data == csum_q) begin
            chrom_d = shadow_q;
            done_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      csum_q   <= '0;
      shadow_q <= '0;
      chrom_q  <= INIT_CHROM;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      shadow_q <= shadow_d;
      chrom_q  <= chrom_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cromossomo = chrom_q;
  assign busy       = (state_q != IDLE);
  assign load_done  = done_q;
  assign load_err   = err_q;
endmodule

// File: tb/tb_chrom_serial_loader.sv
// Directed bench for chrom_serial_loader with a short timeout.
module tb_chrom_serial_loader;
  localparam int W  = 34;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [W-1:0] cromossomo;
  logic         busy, load_done, load_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chrom_serial_loader #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cromossomo (cromossomo),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  // Called at a negedge; returns at the negedge after the strobe is sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, p4, cs);
    send_byte(8'hA5);
    send_byte(p0); send_byte(p1); send_byte(p2); send_byte(p3); send_byte(p4);
    send_byte(cs);
  endtask

  task automatic expect_commit(input string nm, input logic [W-1:0] exp);
    total++;
    if (load_done !== 1'b1 || load_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse: done=%b err=%b busy=%b want done=1 err=0 busy=0",
               nm, load_done, load_err, busy);
    end
    total++;
    if (cromossomo !== exp) begin
      bad++;
      $display("FAIL %s chrom: got %h want %h", nm, cromossomo, exp);
    end
    @(negedge clk);
    total++;
    if (load_done !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse_width: done=%b want 0", nm, load_done);
    end
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (cromossomo !== '0 || busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: chrom=%h busy=%b done=%b err=%b want all 0",
               cromossomo, busy, load_done, load_err);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal;
    send_byte(8'hA5);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL nominal busy: got %b want 1", busy);
    end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h02);
    total++;
    if (cromossomo !== '0 || load_done !== 1'b0) begin
      bad++;
      $display("FAIL nominal early: chrom=%h done=%b want 0 0", cromossomo, load_done);
    end
    send_byte(8'h06);
    expect_commit("nominal", 34'h2_0403_0201);
  endtask

  task automatic test_bad_checksum;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h02, 8'h07);
    total++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || busy !== 1'b0 ||
        cromossomo !== 34'h2_0403_0201) begin
      bad++;
      $display("FAIL bad_cs: err=%b done=%b busy=%b chrom=%h want 1 0 0 204030201",
               load_err, load_done, busy, cromossomo);
    end
    @(negedge clk);
    total++;
    if (load_err !== 1'b0) begin
      bad++;
      $display("FAIL bad_cs width: err=%b want 0", load_err);
    end
  endtask

  task automatic test_junk_sync;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    total++;
    if (busy !== 1'b0 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL junk idle: busy=%b err=%b want 0 0", busy, load_err);
    end
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03);
    expect_commit("junk", 34'h3_FFFF_FFFF);
  endtask

  task automatic test_a5_payload;
    send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5);
    expect_commit("a5_payload", 34'h0_0000_00A5);
  endtask

  task automatic test_timeout;
    int fired = 0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    for (int i = 1; i <= TO + 4; i++) begin
      @(negedge clk);
      if (load_err === 1'b1) begin
        fired = i;
        break;
      end
    end
    total++;
    if (fired != TO) begin
      bad++;
      $display("FAIL timeout cycle: err seen after %0d idle cycles want %0d", fired, TO);
    end
    total++;
    if (busy !== 1'b0 || load_done !== 1'b0 || cromossomo !== 34'h0_0000_00A5) begin
      bad++;
      $display("FAIL timeout state: busy=%b done=%b chrom=%h want 0 0 0000000a5",
               busy, load_done, cromossomo);
    end
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h45);
    expect_commit("after_timeout", 34'h1_4433_2211);
  endtask

  task automatic test_reset_midframe;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
    #2 rst = 1'b1;
    #1;
    total++;
    if (cromossomo !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: chrom=%h busy=%b want 0 0", cromossomo, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'h00);
    expect_commit("after_reset", 34'h0_0D0C_0B0A);
  endtask

  task automatic test_back_to_back;
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00);
    total++;
    if (load_done !== 1'b1 || cromossomo !== 34'h1_0000_0001) begin
      bad++;
      $display("FAIL b2b first: done=%b chrom=%h want 1 100000001", load_done, cromossomo);
    end
    send_frame(8'h80, 8'h40, 8'h20, 8'h10, 8'h00, 8'hF0);
    expect_commit("b2b second", 34'h0_1020_4080);
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_bad_checksum;
    test_junk_sync;
    test_a5_payload;
    test_timeout;
    test_reset_midframe;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/chrom_serial_loader.md
Name: chrom_serial_loader

Overview:
- Receives a chromosome over a byte stream from the host-side UART receiver, validates it, and drives the `cromossomo` bus of the genetic evaluator.
- Double-buffered: the active chromosome changes only after a full frame passes its checksum, in a single cycle.
- Lets the evaluator be reprogrammed at run time without resynthesis.

Parameters:
- ROW, 1, rows of logic elements
- COL, 2, columns of logic elements
- OUT, 1, circuit outputs
- BITS_ELEM, 2, output-select bits per output
- CHROM_W, ROW*COL*16+BITS_ELEM*OUT (default 34), chromosome width
- NBYTES, (CHROM_W+7)/8 (default 5), payload bytes per frame
- TIMEOUT, 50000, maximum idle cycles between bytes inside a frame
- INIT_CHROM, 0, active chromosome value after reset

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- cromossomo  out  CHROM_W  active chromosome to the evaluator
- busy  out  1  frame in progress
- load_done  out  1  one-cycle pulse: new chromosome committed
- load_err  out  1  one-cycle pulse: frame rejected (checksum or timeout)

Behaviour:
- Reset (asynchronous, active-high) forces the following values:
  - cromossomo = INIT_CHROM
  - busy = 0, load_done = 0, load_err = 0
  - shadow register, byte index and checksum = 0
  - state = IDLE
- Frame format: SYNC (8'hA5), then NBYTES payload bytes, then a checksum byte.
- Payload is LSB-first: byte k fills shadow bits [8k+7:8k]. Bits at or above CHROM_W are discarded but still included in the checksum.
- Checksum = XOR of all payload bytes.
- States:
  - IDLE:
    - rx_valid with rx_data == 8'hA5 → PAYLOAD; index = 0, checksum = 0, busy = 1.
    - Any other byte is ignored.
  - PAYLOAD:
    - Each rx_valid writes the byte into the shadow at index and XORs it into the checksum.
    - After byte NBYTES-1 → CHECK.
    - A 0xA5 byte here is data, not a resync.
  - CHECK, on rx_valid:
    - If rx_data == checksum: cromossomo ← shadow and load_done = 1 on the next edge.
    - Otherwise: load_err = 1 and cromossomo is unchanged.
    - Either way → IDLE, busy = 0.
- Latency: cromossomo and the load_done pulse update on the clock edge that samples the checksum byte. The new value is visible in the cycle after the strobe.
- Timeout:
  - In PAYLOAD or CHECK, the gap counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT → IDLE with a 1-cycle load_err pulse; cromossomo is unchanged and the shadow is discarded.
  - The counter is held at 0 in IDLE.
- The shadow is never visible on cromossomo; a partial frame never alters the evaluator.
- load_done and load_err are never asserted in the same cycle. Each pulses for exactly one cycle per frame.
- Reset mid-frame: the frame is dropped and cromossomo returns to INIT_CHROM.
- rx_valid is assumed to be at most one strobe per cycle. There is no backpressure; every strobe is consumed.
- The timeout counter is sized $clog2(TIMEOUT+1) and saturates; it never wraps.

Decomposition:
- Shared package genetic_pkg holds:
  - ROW, COL, OUT, IN, BITS_ELEM, BITS_MAT, CHROM_W, NBYTES
  - SYNC_BYTE = 8'hA5
  - the state enum {IDLE, PAYLOAD, CHECK}
- The top-level includes this package in place of the hard-wired chromosome assignment.
- One sub-module is natural: gap_timer, a saturating counter with clear/enable and a timeout flag. Shadow, checksum and FSM stay inline.

Test Plan:
- Nominal load: after reset, send A5 01 02 03 04 02 06 → load_done one cycle after the 06 strobe. cromossomo = 34'h2_0403_0201 (bits [33:32] = 2'b10); busy low.
- Bad checksum: send A5 01 02 03 04 02 07 → load_err pulse only; cromossomo keeps its previous value (34'h2_0403_0201 after the nominal test).
- Junk before sync: send 00 FF 13 then a valid frame with payload FF FF FF FF 03, checksum 03 → cromossomo = 34'h3_FFFF_FFFF.
- 0xA5 inside payload: send A5 A5 00 00 00 00 A5 → cromossomo = 34'h0_0000_00A5, load_done.
- Timeout (TIMEOUT = 16): send A5 01 02, then idle 16 cycles → load_err, busy = 0, cromossomo unchanged. A following complete valid frame loads correctly.
- Reset mid-frame: send A5 01 02, assert rst → cromossomo = INIT_CHROM, busy = 0. Next full frame loads normally.
